// File: rtl/a7_service_gates_pkg.sv
// Package a7_pkg: shared constants for the A7 service-gate generator.
//   - Bit positions of each read, write and clear gate inside the
//     gate vectors handled by a7_service_gates.
//   - Width of the YT address decode and a helper that performs it.
package a7_pkg;

    localparam int YT_W = 3;
    localparam int YT_N = 1 << YT_W;

    // Read gates (window RT_)
    localparam int RD_A    = 0;
    localparam int RD_BL   = 1;
    localparam int RD_BH   = 2;
    localparam int RD_C    = 3;
    localparam int RD_G    = 4;
    localparam int RD_L    = 5;
    localparam int RD_Q    = 6;
    localparam int RD_U    = 7;
    localparam int RD_Z    = 8;
    localparam int RD_EB   = 9;
    localparam int RD_FB   = 10;
    localparam int RD_BBE  = 11;
    localparam int RD_US   = 12;
    localparam int RD_ULO  = 13;
    localparam int RD_A2X  = 14;
    localparam int RD_L2GD = 15;
    localparam int N_RD    = 16;

    // Write gates (window WT_)
    localparam int WR_A    = 0;
    localparam int WR_B    = 1;
    localparam int WR_L    = 2;
    localparam int WR_Q    = 3;
    localparam int WR_Z    = 4;
    localparam int WR_S    = 5;
    localparam int WR_EB   = 6;
    localparam int WR_FB   = 7;
    localparam int WR_BBE  = 8;
    localparam int WR_YD   = 9;
    localparam int WR_YHI  = 10;
    localparam int WR_YLO  = 11;
    localparam int WR_YDLO = 12;
    localparam int WR_ALS  = 13;
    localparam int WR_G2   = 14;
    localparam int WR_G3   = 15;
    localparam int WR_G4   = 16;
    localparam int WR_G5   = 17;
    localparam int WR_EDOP = 18;
    localparam int N_WR    = 19;

    // Clear gates (window CT_)
    localparam int CL_A    = 0;
    localparam int CL_B    = 1;
    localparam int CL_G    = 2;
    localparam int CL_L1   = 3;
    localparam int CL_L2   = 4;
    localparam int CL_Q    = 5;
    localparam int CL_Z    = 6;
    localparam int CL_EB   = 7;
    localparam int CL_FB   = 8;
    localparam int CL_S    = 9;
    localparam int CL_U    = 10;
    localparam int N_CL    = 11;

    // One-hot YT select; all lines low while the enable (active-low) is high.
    function automatic logic [YT_N-1:0] yt_decode(input logic [YT_W-1:0] sel,
                                                  input logic en_n);
        logic [YT_N-1:0] one;
        one    = '0;
        one[0] = 1'b1;
        return en_n ? '0 : (one << sel);
    endfunction

endpackage

// File: rtl/a7_service_gates_if.sv
// a7_service_gates_if: bundle between the control-pulse decoder (master)
// and the A7 service-gate generator (slave).
//   master drives: read/write pulses, timing windows, edit/inhibit/zap
//                  controls, misc controls and address decode.
//   slave drives : read/write/clear gates, buffered/aux signals, monitor
//                  strobes and YT address-select lines.
interface a7_service_gates_if;

    logic RA_, RB_, RC_, RG_, RL_, RQ_, RU_, RZ_, RCHG_, RSCG_, RUS_, A2X_, L2GD_;
    logic WA_, WB_, WG_, WGA_, WL_, WQ_, WS_, WY_, WY12_, WYD_, WZ_, WCHG_, WSCG_;
    logic RT_, WT_, CT_, TT_, T10_;
    logic CYL_, CYR_, SR_, EDOP_, SHIFT, GINH, ZAP_, L15_;
    logic CI, NEAC, EAC_, P04_, PIFL_, PIPPLS_, STFET1_, U2BBK, RL10BB, SB2_, CGA7, CGMC;
    logic EAD09, EAD10, EAD11, EAD09_, EAD10_, EAD11_;
    logic XB0_, XB1_, XB2_, XB3_, XB4_, XB5_, XB6_, XT0_;

    logic RAG_, RBLG_, RBHG_, RCG_, RGG_, RLG_, RQG_, RUG_, RZG_, REBG_, RFBG_, RBBEG_;
    logic RUSG_, RULOG_, A2XG_, L2GDG_;
    logic WAG_, WBG_, WLG_, WQG_, WZG_, WSG_, WEBG_, WFBG_, WBBEG_, WYDG_, WYHIG_, WYLOG_;
    logic WYDLOG_, WG1G_, WG2G_, WG3G_, WG4G_, WG5G_, WEDOPG_, WALSG_;
    logic CAG, CBG, CGG, CLG1G, CLG2G, CQG, CZG, CEBG, CFBG, CSG, CUG;
    logic RGG1, RLG1, RLG2, RLG3, WALSG, G2LSG, G2LSG_, WGNORM, CINORM, CIFF, CI01_;
    logic PIPSAM, P04A, RBBK;
    logic MRAG, MRGG, MRLG, MRULOG, MWAG, MWBG, MWBBEG, MWEBG, MWFBG, MWG, MWLG, MWQG;
    logic MWSG, MWYG, MWZG;
    logic YT0, YT1, YT2, YT3, YT4, YT5, YT6, YT7;
    logic YT0_, YT1_, YT2_, YT3_, YT4_, YT5_, YT6_, YT7_;
    logic YT0E, YT1E, YT2E, YT3E, YT4E, YT5E, YT6E, YT7E;

    modport slave (
        input  RA_, RB_, RC_, RG_, RL_, RQ_, RU_, RZ_, RCHG_, RSCG_, RUS_, A2X_, L2GD_,
        input  WA_, WB_, WG_, WGA_, WL_, WQ_, WS_, WY_, WY12_, WYD_, WZ_, WCHG_, WSCG_,
        input  RT_, WT_, CT_, TT_, T10_, CYL_, CYR_, SR_, EDOP_, SHIFT, GINH, ZAP_, L15_,
        input  CI, NEAC, EAC_, P04_, PIFL_, PIPPLS_, STFET1_, U2BBK, RL10BB, SB2_, CGA7, CGMC,
        input  EAD09, EAD10, EAD11, EAD09_, EAD10_, EAD11_,
        input  XB0_, XB1_, XB2_, XB3_, XB4_, XB5_, XB6_, XT0_,
        output RAG_, RBLG_, RBHG_, RCG_, RGG_, RLG_, RQG_, RUG_, RZG_, REBG_, RFBG_, RBBEG_,
        output RUSG_, RULOG_, A2XG_, L2GDG_,
        output WAG_, WBG_, WLG_, WQG_, WZG_, WSG_, WEBG_, WFBG_, WBBEG_, WYDG_, WYHIG_, WYLOG_,
        output WYDLOG_, WG1G_, WG2G_, WG3G_, WG4G_, WG5G_, WEDOPG_, WALSG_,
        output CAG, CBG, CGG, CLG1G, CLG2G, CQG, CZG, CEBG, CFBG, CSG, CUG,
        output RGG1, RLG1, RLG2, RLG3, WALSG, G2LSG, G2LSG_, WGNORM, CINORM, CIFF, CI01_,
        output PIPSAM, P04A, RBBK,
        output MRAG, MRGG, MRLG, MRULOG, MWAG, MWBG, MWBBEG, MWEBG, MWFBG, MWG, MWLG, MWQG,
        output MWSG, MWYG, MWZG,
        output YT0, YT1, YT2, YT3, YT4, YT5, YT6, YT7,
        output YT0_, YT1_, YT2_, YT3_, YT4_, YT5_, YT6_, YT7_,
        output YT0E, YT1E, YT2E, YT3E, YT4E, YT5E, YT6E, YT7E
    );

    modport master (
        output RA_, RB_, RC_, RG_, RL_, RQ_, RU_, RZ_, RCHG_, RSCG_, RUS_, A2X_, L2GD_,
        output WA_, WB_, WG_, WGA_, WL_, WQ_, WS_, WY_, WY12_, WYD_, WZ_, WCHG_, WSCG_,
        output RT_, WT_, CT_, TT_, T10_, CYL_, CYR_, SR_, EDOP_, SHIFT, GINH, ZAP_, L15_,
        output CI, NEAC, EAC_, P04_, PIFL_, PIPPLS_, STFET1_, U2BBK, RL10BB, SB2_, CGA7, CGMC,
        output EAD09, EAD10, EAD11, EAD09_, EAD10_, EAD11_,
        output XB0_, XB1_, XB2_, XB3_, XB4_, XB5_, XB6_, XT0_,
        input  RAG_, RBLG_, RBHG_, RCG_, RGG_, RLG_, RQG_, RUG_, RZG_, REBG_, RFBG_, RBBEG_,
        input  RUSG_, RULOG_, A2XG_, L2GDG_,
        input  WAG_, WBG_, WLG_, WQG_, WZG_, WSG_, WEBG_, WFBG_, WBBEG_, WYDG_, WYHIG_, WYLOG_,
        input  WYDLOG_, WG1G_, WG2G_, WG3G_, WG4G_, WG5G_, WEDOPG_, WALSG_,
        input  CAG, CBG, CGG, CLG1G, CLG2G, CQG, CZG, CEBG, CFBG, CSG, CUG,
        input  RGG1, RLG1, RLG2, RLG3, WALSG, G2LSG, G2LSG_, WGNORM, CINORM, CIFF, CI01_,
        input  PIPSAM, P04A, RBBK,
        input  MRAG, MRGG, MRLG, MRULOG, MWAG, MWBG, MWBBEG, MWEBG, MWFBG, MWG, MWLG, MWQG,
        input  MWSG, MWYG, MWZG,
        input  YT0, YT1, YT2, YT3, YT4, YT5, YT6, YT7,
        input  YT0_, YT1_, YT2_, YT3_, YT4_, YT5_, YT6_, YT7_,
        input  YT0E, YT1E, YT2E, YT3E, YT4E, YT5E, YT6E, YT7E
    );

endinterface

// File: rtl/a7_timed_gate.sv
// a7_timed_gate: one service gate = active-low pulse qualified by an
// active-low timing window.
//   pulse_n  in   control pulse, active-low
//   window_n in   timing window (RT_/WT_/CT_), active-low
//   gate_n   out  gate, active-low (read/write gates)
//   gate     out  gate, active-high (clear gates)
module a7_timed_gate (
    input  logic pulse_n,
    input  logic window_n,
    output logic gate_n,
    output logic gate
);

    assign gate_n = pulse_n | window_n;
    assign gate   = ~gate_n;

endmodule

// File: rtl/a7_service_gates.sv
// a7_service_gates: AGC A7 service-gate generator.
//   CLOCK  in  system clock, rising edge (only CIFF and PIPSAM use it)
//   rst    in  asynchronous reset, active-high
//   bus    a7_service_gates_if.slave: pulses/windows/controls in;
//          read, write, clear gates, aux, monitor and YT lines out.
// All gates are combinational. Build option A7_MONITOR_EN: when defined
// the M* monitor strobes image their gates; otherwise they are tied low.
module a7_service_gates (
    input  logic                      CLOCK,
    input  logic                      rst,
    a7_service_gates_if.slave         bus
);
    import a7_pkg::*;

    logic [N_RD-1:0] w_rd_pulse_n, w_rd_gate_n, w_unused_rd;
    logic [N_WR-1:0] w_wr_pulse_n, w_wr_gate_n, w_unused_wr;
    logic [N_CL-1:0] w_cl_pulse_n, w_cl_gate,   w_unused_cl;
    logic [YT_N-1:0] w_yt, w_yte;
    logic            w_wg1g_n;
    logic            r_ciff, r_pipsam;
    logic            w_unused;

    // Bank-register (EB/FB/BB) gates are the S-register channel pulse
    // qualified by the XB address decode of locations 3, 4 and 6.
    always_comb begin
        w_rd_pulse_n          = '1;
        w_rd_pulse_n[RD_A]    = bus.RA_;
        w_rd_pulse_n[RD_BL]   = bus.RB_;
        w_rd_pulse_n[RD_BH]   = bus.RB_;
        w_rd_pulse_n[RD_C]    = bus.RC_;
        w_rd_pulse_n[RD_G]    = bus.RG_;
        w_rd_pulse_n[RD_L]    = bus.RL_;
        w_rd_pulse_n[RD_Q]    = bus.RQ_;
        w_rd_pulse_n[RD_U]    = bus.RU_ & bus.ZAP_;
        w_rd_pulse_n[RD_Z]    = bus.RZ_;
        w_rd_pulse_n[RD_EB]   = bus.RSCG_ | bus.XB3_;
        w_rd_pulse_n[RD_FB]   = bus.RSCG_ | bus.XB4_;
        w_rd_pulse_n[RD_BBE]  = bus.RSCG_ | bus.XB6_;
        w_rd_pulse_n[RD_US]   = bus.RUS_;
        w_rd_pulse_n[RD_ULO]  = bus.RU_ & bus.RUS_;
        w_rd_pulse_n[RD_A2X]  = bus.A2X_;
        w_rd_pulse_n[RD_L2GD] = bus.L2GD_;
    end

    // G-edit sources are folded with GINH here so the inhibit always wins.
    always_comb begin
        w_wr_pulse_n          = '1;
        w_wr_pulse_n[WR_A]    = bus.WA_;
        w_wr_pulse_n[WR_B]    = bus.WB_;
        w_wr_pulse_n[WR_L]    = bus.WL_;
        w_wr_pulse_n[WR_Q]    = bus.WQ_;
        w_wr_pulse_n[WR_Z]    = bus.WZ_;
        w_wr_pulse_n[WR_S]    = bus.WS_;
        w_wr_pulse_n[WR_EB]   = bus.WSCG_ | bus.XB3_;
        w_wr_pulse_n[WR_FB]   = bus.WSCG_ | bus.XB4_;
        w_wr_pulse_n[WR_BBE]  = bus.WSCG_ | bus.XB6_;
        w_wr_pulse_n[WR_YD]   = bus.WYD_;
        w_wr_pulse_n[WR_YHI]  = bus.WY_;
        w_wr_pulse_n[WR_YLO]  = bus.WY_ & bus.WY12_;
        w_wr_pulse_n[WR_YDLO] = bus.WYD_;
        w_wr_pulse_n[WR_ALS]  = bus.ZAP_;
        w_wr_pulse_n[WR_G2]   = bus.CYL_  | bus.GINH;
        w_wr_pulse_n[WR_G3]   = bus.CYR_  | bus.GINH;
        w_wr_pulse_n[WR_G4]   = bus.SR_   | bus.GINH;
        w_wr_pulse_n[WR_G5]   = bus.EDOP_ | bus.GINH;
        w_wr_pulse_n[WR_EDOP] = bus.EDOP_ | bus.GINH;
    end

    // Writing any Y input clears U, so CUG takes the OR of the Y writes.
    always_comb begin
        w_cl_pulse_n        = '1;
        w_cl_pulse_n[CL_A]  = bus.WA_;
        w_cl_pulse_n[CL_B]  = bus.WB_;
        w_cl_pulse_n[CL_G]  = bus.WG_ & ~bus.CGMC;
        w_cl_pulse_n[CL_L1] = bus.WL_;
        w_cl_pulse_n[CL_L2] = bus.WL_;
        w_cl_pulse_n[CL_Q]  = bus.WQ_;
        w_cl_pulse_n[CL_Z]  = bus.WZ_;
        w_cl_pulse_n[CL_EB] = bus.WSCG_ | bus.XB3_;
        w_cl_pulse_n[CL_FB] = bus.WSCG_ | bus.XB4_;
        w_cl_pulse_n[CL_S]  = bus.WS_;
        w_cl_pulse_n[CL_U]  = bus.WY_ & bus.WY12_ & bus.WYD_;
    end

    for (genvar i = 0; i < N_RD; i++) begin : g_rd
        a7_timed_gate u_gate (.pulse_n(w_rd_pulse_n[i]), .window_n(bus.RT_),
                              .gate_n(w_rd_gate_n[i]), .gate(w_unused_rd[i]));
    end
    for (genvar i = 0; i < N_WR; i++) begin : g_wr
        a7_timed_gate u_gate (.pulse_n(w_wr_pulse_n[i]), .window_n(bus.WT_),
                              .gate_n(w_wr_gate_n[i]), .gate(w_unused_wr[i]));
    end
    for (genvar i = 0; i < N_CL; i++) begin : g_cl
        a7_timed_gate u_gate (.pulse_n(w_cl_pulse_n[i]), .window_n(bus.CT_),
                              .gate_n(w_unused_cl[i]), .gate(w_cl_gate[i]));
    end

    // WG1G_ is the only G write gate not qualified by WT_.
    assign w_wg1g_n = bus.GINH | bus.SHIFT | (bus.WG_ & bus.WGA_);

    assign bus.RAG_   = w_rd_gate_n[RD_A];    assign bus.RBLG_  = w_rd_gate_n[RD_BL];
    assign bus.RBHG_  = w_rd_gate_n[RD_BH];   assign bus.RCG_   = w_rd_gate_n[RD_C];
    assign bus.RGG_   = w_rd_gate_n[RD_G];    assign bus.RLG_   = w_rd_gate_n[RD_L];
    assign bus.RQG_   = w_rd_gate_n[RD_Q];    assign bus.RUG_   = w_rd_gate_n[RD_U];
    assign bus.RZG_   = w_rd_gate_n[RD_Z];    assign bus.REBG_  = w_rd_gate_n[RD_EB];
    assign bus.RFBG_  = w_rd_gate_n[RD_FB];   assign bus.RBBEG_ = w_rd_gate_n[RD_BBE];
    assign bus.RUSG_  = w_rd_gate_n[RD_US];   assign bus.RULOG_ = w_rd_gate_n[RD_ULO];
    assign bus.A2XG_  = w_rd_gate_n[RD_A2X];  assign bus.L2GDG_ = w_rd_gate_n[RD_L2GD];

    assign bus.WAG_    = w_wr_gate_n[WR_A];    assign bus.WBG_    = w_wr_gate_n[WR_B];
    assign bus.WLG_    = w_wr_gate_n[WR_L];    assign bus.WQG_    = w_wr_gate_n[WR_Q];
    assign bus.WZG_    = w_wr_gate_n[WR_Z];    assign bus.WSG_    = w_wr_gate_n[WR_S];
    assign bus.WEBG_   = w_wr_gate_n[WR_EB];   assign bus.WFBG_   = w_wr_gate_n[WR_FB];
    assign bus.WBBEG_  = w_wr_gate_n[WR_BBE];  assign bus.WYDG_   = w_wr_gate_n[WR_YD];
    assign bus.WYHIG_  = w_wr_gate_n[WR_YHI];  assign bus.WYLOG_  = w_wr_gate_n[WR_YLO];
    assign bus.WYDLOG_ = w_wr_gate_n[WR_YDLO]; assign bus.WALSG_  = w_wr_gate_n[WR_ALS];
    assign bus.WG1G_   = w_wg1g_n;             assign bus.WG2G_   = w_wr_gate_n[WR_G2];
    assign bus.WG3G_   = w_wr_gate_n[WR_G3];   assign bus.WG4G_   = w_wr_gate_n[WR_G4];
    assign bus.WG5G_   = w_wr_gate_n[WR_G5];   assign bus.WEDOPG_ = w_wr_gate_n[WR_EDOP];

    assign bus.CAG   = w_cl_gate[CL_A];   assign bus.CBG   = w_cl_gate[CL_B];
    assign bus.CGG   = w_cl_gate[CL_G];   assign bus.CLG1G = w_cl_gate[CL_L1];
    assign bus.CLG2G = w_cl_gate[CL_L2];  assign bus.CQG   = w_cl_gate[CL_Q];
    assign bus.CZG   = w_cl_gate[CL_Z];   assign bus.CEBG  = w_cl_gate[CL_EB];
    assign bus.CFBG  = w_cl_gate[CL_FB];  assign bus.CSG   = w_cl_gate[CL_S];
    assign bus.CUG   = w_cl_gate[CL_U];

    assign bus.RGG1   = ~w_rd_gate_n[RD_G];
    assign bus.RLG1   = ~w_rd_gate_n[RD_L];
    assign bus.RLG2   = ~w_rd_gate_n[RD_L];
    assign bus.RLG3   = ~w_rd_gate_n[RD_L];
    assign bus.WALSG  = ~w_wr_gate_n[WR_ALS];
    assign bus.G2LSG  = (~bus.L2GD_ | ~bus.ZAP_) & ~bus.WT_;
    assign bus.G2LSG_ = ~((~bus.L2GD_ | ~bus.ZAP_) & ~bus.WT_);
    assign bus.WGNORM = ~bus.WG_ & ~bus.SHIFT;
    assign bus.P04A   = ~bus.P04_;
    assign bus.RBBK   = ~w_rd_gate_n[RD_BBE] & bus.U2BBK;

    assign w_yt  = yt_decode({bus.EAD11, bus.EAD10, bus.EAD09}, bus.XT0_);
    assign w_yte = w_yt & {YT_N{~bus.EAC_ & ~bus.NEAC}};
    assign {bus.YT7, bus.YT6, bus.YT5, bus.YT4, bus.YT3, bus.YT2, bus.YT1, bus.YT0} = w_yt;
    assign {bus.YT7_, bus.YT6_, bus.YT5_, bus.YT4_,
            bus.YT3_, bus.YT2_, bus.YT1_, bus.YT0_} = ~w_yt;
    assign {bus.YT7E, bus.YT6E, bus.YT5E, bus.YT4E,
            bus.YT3E, bus.YT2E, bus.YT1E, bus.YT0E} = w_yte;

    // Carry-in flip-flop: set has priority over the TT_ clear.
    always_ff @(posedge CLOCK or posedge rst) begin
        if (rst)          r_ciff <= 1'b0;
        else if (bus.CI)  r_ciff <= 1'b1;
        else if (!bus.TT_) r_ciff <= 1'b0;
    end

    // PIPA sample taken only during T10.
    always_ff @(posedge CLOCK or posedge rst) begin
        if (rst)           r_pipsam <= 1'b0;
        else if (!bus.T10_) r_pipsam <= ~bus.PIPPLS_;
    end

    assign bus.CIFF   = r_ciff;
    assign bus.PIPSAM = r_pipsam;
    assign bus.CINORM = r_ciff & ~bus.CT_;
    assign bus.CI01_  = ~(r_ciff | ~bus.L15_);

`ifdef A7_MONITOR_EN
    assign bus.MRAG   = ~w_rd_gate_n[RD_A];
    assign bus.MRGG   = ~w_rd_gate_n[RD_G];
    assign bus.MRLG   = ~w_rd_gate_n[RD_L];
    assign bus.MRULOG = ~w_rd_gate_n[RD_ULO];
    assign bus.MWAG   = ~w_wr_gate_n[WR_A];
    assign bus.MWBG   = ~w_wr_gate_n[WR_B];
    assign bus.MWBBEG = ~w_wr_gate_n[WR_BBE];
    assign bus.MWEBG  = ~w_wr_gate_n[WR_EB];
    assign bus.MWFBG  = ~w_wr_gate_n[WR_FB];
    assign bus.MWG    = ~w_wg1g_n | bus.CGA7;
    assign bus.MWLG   = ~w_wr_gate_n[WR_L];
    assign bus.MWQG   = ~w_wr_gate_n[WR_Q];
    assign bus.MWSG   = ~w_wr_gate_n[WR_S];
    assign bus.MWYG   = ~(w_wr_gate_n[WR_YLO] & w_wr_gate_n[WR_YHI]);
    assign bus.MWZG   = ~w_wr_gate_n[WR_Z];
`else
    assign {bus.MRAG, bus.MRGG, bus.MRLG, bus.MRULOG, bus.MWAG, bus.MWBG, bus.MWBBEG,
            bus.MWEBG, bus.MWFBG, bus.MWG, bus.MWLG, bus.MWQG, bus.MWSG, bus.MWYG,
            bus.MWZG} = '0;
`endif

    // Inputs carried on the bus that no gate in this block consumes.
    assign w_unused = ^{bus.PIFL_, bus.STFET1_, bus.RL10BB, bus.SB2_, bus.CGA7,
                        bus.EAD09_, bus.EAD10_, bus.EAD11_, bus.XB0_, bus.XB1_,
                        bus.XB2_, bus.XB5_, bus.RCHG_, bus.WCHG_,
                        w_unused_rd, w_unused_wr, w_unused_cl};

endmodule

// File: tb/tb_a7_service_gates.sv
module tb_a7_service_gates;

    logic CLOCK = 1'b0;
    logic rst;

    a7_service_gates_if bus();

    a7_service_gates dut (.CLOCK(CLOCK), .rst(rst), .bus(bus));

    always #5 CLOCK = ~CLOCK;

`ifdef A7_MONITOR_EN
    localparam logic MON = 1'b1;
`else
    localparam logic MON = 1'b0;
`endif

    typedef struct {
        string tag;
        logic  v;
    } exp_t;

    exp_t sb[$];
    int   n_chk  = 0;
    int   n_pass = 0;

    task automatic push(input string tag, input logic v);
        exp_t e;
        e.tag = tag;
        e.v   = v;
        sb.push_back(e);
    endtask

    task automatic chk(input logic obs);
        exp_t e;
        n_chk++;
        if (sb.size() == 0) begin
            $error("FAIL scoreboard_empty got=%b want=entry", obs);
            return;
        end
        e = sb.pop_front();
        assert (obs === e.v) n_pass++;
        else $error("FAIL %s got=%b want=%b", e.tag, obs, e.v);
    endtask

    task automatic init_inputs();
        {bus.RA_, bus.RB_, bus.RC_, bus.RG_, bus.RL_, bus.RQ_, bus.RU_, bus.RZ_} = '1;
        {bus.RCHG_, bus.RSCG_, bus.RUS_, bus.A2X_, bus.L2GD_} = '1;
        {bus.WA_, bus.WB_, bus.WG_, bus.WGA_, bus.WL_, bus.WQ_, bus.WS_, bus.WY_} = '1;
        {bus.WY12_, bus.WYD_, bus.WZ_, bus.WCHG_, bus.WSCG_} = '1;
        {bus.RT_, bus.WT_, bus.CT_, bus.TT_, bus.T10_} = '1;
        {bus.CYL_, bus.CYR_, bus.SR_, bus.EDOP_, bus.ZAP_, bus.L15_} = '1;
        bus.SHIFT = 1'b0; bus.GINH = 1'b0;
        bus.CI = 1'b0; bus.NEAC = 1'b0; bus.EAC_ = 1'b1; bus.P04_ = 1'b1;
        bus.PIFL_ = 1'b1; bus.PIPPLS_ = 1'b1; bus.STFET1_ = 1'b1; bus.U2BBK = 1'b0;
        bus.RL10BB = 1'b0; bus.SB2_ = 1'b1; bus.CGA7 = 1'b0; bus.CGMC = 1'b0;
        {bus.EAD09, bus.EAD10, bus.EAD11} = '0;
        {bus.EAD09_, bus.EAD10_, bus.EAD11_} = '1;
        {bus.XB0_, bus.XB1_, bus.XB2_, bus.XB3_, bus.XB4_, bus.XB5_, bus.XB6_, bus.XT0_} = '1;
    endtask

    initial begin
        rst = 1'b1;
        init_inputs();
        bus.CI = 1'b1;
        @(posedge CLOCK); #1;
        push("rst_CIFF", 0);   push("rst_PIPSAM", 0); push("rst_RAG_", 1);
        push("rst_WG1G_", 1);  push("rst_CAG", 0);    push("rst_CGG", 0);
        push("rst_CI01_", 1);  push("rst_YT0", 0);    push("rst_MRAG", 0);
        chk(bus.CIFF); chk(bus.PIPSAM); chk(bus.RAG_); chk(bus.WG1G_); chk(bus.CAG);
        chk(bus.CGG);  chk(bus.CI01_);  chk(bus.YT0);  chk(bus.MRAG);
        bus.CI = 1'b0;
        @(negedge CLOCK); rst = 1'b0;

        // read gate A and the shared B gates
        bus.RA_ = 0; bus.RT_ = 0; #1;
        push("rd_RAG_", 0); push("rd_MRAG", MON); push("rd_RBLG_idle", 1);
        chk(bus.RAG_); chk(bus.MRAG); chk(bus.RBLG_);
        bus.RT_ = 1; #1;
        push("rd_RAG_off", 1); push("rd_MRAG_off", 0);
        chk(bus.RAG_); chk(bus.MRAG);
        bus.RA_ = 1; bus.RB_ = 0; bus.RT_ = 0; #1;
        push("rd_RBLG_", 0); push("rd_RBHG_", 0); push("rd_RAG_idle", 1);
        chk(bus.RBLG_); chk(bus.RBHG_); chk(bus.RAG_);
        bus.RB_ = 1; bus.RT_ = 1;

        // G write gates and GINH priority
        bus.WG_ = 0; bus.WT_ = 0; bus.SHIFT = 0; #1;
        push("wg_WG1G_", 0); push("wg_WGNORM", 1); push("wg_MWG", MON);
        chk(bus.WG1G_); chk(bus.WGNORM); chk(bus.MWG);
        bus.GINH = 1; bus.CYL_ = 0; #1;
        push("wg_WG1G_ginh", 1); push("wg_WGNORM_ginh", 1); push("wg_WG2G_ginh", 1);
        chk(bus.WG1G_); chk(bus.WGNORM); chk(bus.WG2G_);
        bus.GINH = 0; #1;
        push("wg_WG2G_", 0); chk(bus.WG2G_);
        bus.SHIFT = 1; #1;
        push("wg_WG1G_shift", 1); push("wg_WGNORM_shift", 0);
        chk(bus.WG1G_); chk(bus.WGNORM);
        bus.WG_ = 1; bus.SHIFT = 0; bus.CYL_ = 1; bus.WT_ = 1;

        // clear gates
        bus.WA_ = 0; bus.CT_ = 0; #1;
        push("cl_CAG", 1); push("cl_WAG_noWT", 1); chk(bus.CAG); chk(bus.WAG_);
        bus.WA_ = 1; bus.CGMC = 1; #1;
        push("cl_CGG_cgmc", 1); push("cl_CAG_off", 0); chk(bus.CGG); chk(bus.CAG);
        bus.CT_ = 1; #1;
        push("cl_CGG_noCT", 0); chk(bus.CGG);
        bus.CGMC = 0;

        // YT select
        bus.EAD11 = 1; bus.EAD10 = 0; bus.EAD09 = 1; bus.XT0_ = 0;
        bus.EAC_ = 0; bus.NEAC = 0; #1;
        push("yt_YT5", 1); push("yt_YT5E", 1); push("yt_YT5_", 0);
        push("yt_YT4", 0); push("yt_YT0", 0);  push("yt_YT7E", 0);
        chk(bus.YT5); chk(bus.YT5E); chk(bus.YT5_); chk(bus.YT4); chk(bus.YT0); chk(bus.YT7E);
        bus.NEAC = 1; #1;
        push("yt_YT5E_neac", 0); push("yt_YT5_neac", 1); chk(bus.YT5E); chk(bus.YT5);
        bus.XT0_ = 1; #1;
        push("yt_YT5_xt", 0); chk(bus.YT5);
        bus.NEAC = 0; bus.EAC_ = 1;
        bus.P04_ = 0; #1;
        push("aux_P04A", 1); chk(bus.P04A);
        bus.P04_ = 1;

        // CIFF
        bus.CI = 1; @(posedge CLOCK); #1;
        push("ci_CIFF_set", 1); push("ci_CI01_", 0); push("ci_CINORM_noCT", 0);
        chk(bus.CIFF); chk(bus.CI01_); chk(bus.CINORM);
        bus.CI = 0; @(posedge CLOCK); #1;
        push("ci_CIFF_hold", 1); chk(bus.CIFF);
        bus.CI = 1; bus.TT_ = 0; @(posedge CLOCK); #1;
        push("ci_CIFF_setwins", 1); chk(bus.CIFF);
        bus.CT_ = 0; #1;
        push("ci_CINORM", 1); chk(bus.CINORM);
        bus.CT_ = 1; bus.CI = 0; @(posedge CLOCK); #1;
        push("ci_CIFF_clr", 0); push("ci_CI01_clr", 1); chk(bus.CIFF); chk(bus.CI01_);
        bus.TT_ = 1; bus.L15_ = 0; #1;
        push("ci_CI01_L15", 0); chk(bus.CI01_);
        bus.L15_ = 1;

        // PIPSAM
        bus.PIPPLS_ = 0; @(posedge CLOCK); #1;
        push("pip_noT10", 0); chk(bus.PIPSAM);
        bus.T10_ = 0; @(posedge CLOCK); #1;
        push("pip_load", 1); chk(bus.PIPSAM);
        bus.T10_ = 1; bus.PIPPLS_ = 1; @(posedge CLOCK); #1;
        push("pip_hold", 1); chk(bus.PIPSAM);

        // ZAP and asynchronous reset mid-operation
        bus.ZAP_ = 0; bus.RT_ = 0; bus.WT_ = 0; #1;
        push("zap_RUG_", 0); push("zap_WALSG", 1); push("zap_G2LSG", 1); push("zap_G2LSG_", 0);
        chk(bus.RUG_); chk(bus.WALSG); chk(bus.G2LSG); chk(bus.G2LSG_);
        bus.CI = 1; @(posedge CLOCK); #1;
        push("ar_CIFF_pre", 1); push("ar_PIPSAM_pre", 1); chk(bus.CIFF); chk(bus.PIPSAM);
        bus.CI = 0; #2;
        rst = 1'b1; #1;
        push("ar_CIFF", 0); push("ar_PIPSAM", 0); push("ar_CI01_", 1);
        chk(bus.CIFF); chk(bus.PIPSAM); chk(bus.CI01_);
        @(negedge CLOCK); rst = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
